// File: rtl/histogram_median_reader.sv
// histogram_median_reader
//   Reads one frame's x/y projection histograms into local buffers and sums
//   each axis. It then runs the histogram clear handshake and scans both
//   buffers in parallel for the median column and median row.
//
//   State table
//   state | meaning
//   IDLE  | waiting for start
//   READ  | readHistogram high, capturing x/y bin streams
//   GAP   | one quiet cycle so the histogram block can rewind its counters
//   CLEAR | clearHistogram high until histogramCleared is seen
//   SCAN  | one bin index per cycle, cumulative sum against half total
//   DONE  | results updated, medianValid high
//
//   Ports
//   clk, reset                    clock, synchronous active-high reset
//   start                         pulse that begins a cycle (ignored when busy)
//   xHistogramIn/xValid           x projection stream
//   yHistogramIn/yValid           y projection stream
//   histogramCleared              histogram block finished clearing
//   readHistogram/clearHistogram  requests to the histogram block
//   xMedian/yMedian               median column/row
//   xTotal/yTotal                 per-axis sum of captured bins
//   noObject                      xTotal was zero
//   medianValid                   one-cycle result strobe
//   busy                          high in every state except IDLE
module histogram_median_reader #(
    parameter int IMWIDTH      = 240,
    parameter int IMHEIGHT     = 180,
    parameter int READ_TIMEOUT = 300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  xHistogramIn,
    input  logic [7:0]  yHistogramIn,
    input  logic        xValid,
    input  logic        yValid,
    input  logic        histogramCleared,
    output logic        readHistogram,
    output logic        clearHistogram,
    output logic [7:0]  xMedian,
    output logic [7:0]  yMedian,
    output logic [15:0] xTotal,
    output logic [15:0] yTotal,
    output logic        noObject,
    output logic        medianValid,
    output logic        busy
);

    localparam int SCAN_LEN = (IMWIDTH > IMHEIGHT) ? IMWIDTH : IMHEIGHT;
    localparam int TW       = $clog2(READ_TIMEOUT + 1);

    localparam logic [7:0]    X_LEN     = 8'(IMWIDTH);
    localparam logic [7:0]    Y_LEN     = 8'(IMHEIGHT);
    localparam logic [7:0]    SCAN_LAST = 8'(SCAN_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, READ, GAP, CLEAR, SCAN, DONE} state_t;

    state_t state, nextState;

    logic [7:0]    xBuf [IMWIDTH];
    logic [7:0]    yBuf [IMHEIGHT];
    logic [7:0]    xWr, yWr;
    logic [15:0]   xSum, ySum;
    logic [TW-1:0] tmo;
    logic          xValidD, yValidD;
    logic          xDone, yDone;
    logic [7:0]    scanIdx;
    logic [15:0]   xCum, yCum;
    logic          xFound, yFound;
    logic [7:0]    xMed, yMed;

    logic          xWrEn, yWrEn;
    logic          xDoneNow, yDoneNow, readExit;
    logic [16:0]   xSumP1, ySumP1;
    logic [15:0]   xHalf, yHalf;
    logic [7:0]    xBin, yBin;
    logic [15:0]   xCumNext, yCumNext;
    logic          xHit, yHit;
    logic [7:0]    xMedNext, yMedNext;

    assign xWrEn = (state == READ) && xValid && (xWr < X_LEN);
    assign yWrEn = (state == READ) && yValid && (yWr < Y_LEN);

    // An axis finishes on a falling valid after data, or when its buffer is full.
    assign xDoneNow = xDone || (xWr == X_LEN) || (xValidD && !xValid && (xWr != 8'd0));
    assign yDoneNow = yDone || (yWr == Y_LEN) || (yValidD && !yValid && (yWr != 8'd0));
    assign readExit = (xDoneNow && yDoneNow) || (tmo == TMO_LAST);

    // Rounded-up half of the total; 17 bits so a full-scale sum cannot wrap.
    assign xSumP1 = {1'b0, xSum} + 17'd1;
    assign ySumP1 = {1'b0, ySum} + 17'd1;
    assign xHalf  = xSumP1[16:1];
    assign yHalf  = ySumP1[16:1];

    // Bins never written this frame (short stream or timeout) count as zero.
    assign xBin     = (scanIdx < xWr) ? xBuf[scanIdx] : 8'd0;
    assign yBin     = (scanIdx < yWr) ? yBuf[scanIdx] : 8'd0;
    assign xCumNext = xCum + {8'd0, xBin};
    assign yCumNext = yCum + {8'd0, yBin};
    assign xHit     = !xFound && (xCumNext >= xHalf);
    assign yHit     = !yFound && (yCumNext >= yHalf);
    assign xMedNext = xHit ? scanIdx : xMed;
    assign yMedNext = yHit ? scanIdx : yMed;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = READ;
            READ:    if (readExit) nextState = GAP;
            GAP:     nextState = CLEAR;
            CLEAR:   if (histogramCleared) nextState = SCAN;
            SCAN:    if (scanIdx == SCAN_LAST) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xWrEn) xBuf[xWr] <= xHistogramIn;
        if (yWrEn) yBuf[yWr] <= yHistogramIn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            readHistogram  <= 1'b0;
            clearHistogram <= 1'b0;
            busy           <= 1'b0;
            medianValid    <= 1'b0;
            xMedian        <= '0;
            yMedian        <= '0;
            xTotal         <= '0;
            yTotal         <= '0;
            noObject       <= 1'b0;
            xWr            <= '0;
            yWr            <= '0;
            xSum           <= '0;
            ySum           <= '0;
            tmo            <= '0;
            xValidD        <= 1'b0;
            yValidD        <= 1'b0;
            xDone          <= 1'b0;
            yDone          <= 1'b0;
            scanIdx        <= '0;
            xCum           <= '0;
            yCum           <= '0;
            xFound         <= 1'b0;
            yFound         <= 1'b0;
            xMed           <= '0;
            yMed           <= '0;
        end else begin
            state <= nextState;
            // Request/status outputs follow the state being entered so they
            // line up with that state while staying registered.
            readHistogram  <= (nextState == READ);
            clearHistogram <= (nextState == CLEAR);
            busy           <= (nextState != IDLE);
            medianValid    <= (nextState == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        xWr     <= '0;
                        yWr     <= '0;
                        xSum    <= '0;
                        ySum    <= '0;
                        tmo     <= '0;
                        xValidD <= 1'b0;
                        yValidD <= 1'b0;
                        xDone   <= 1'b0;
                        yDone   <= 1'b0;
                        scanIdx <= '0;
                        xCum    <= '0;
                        yCum    <= '0;
                        xFound  <= 1'b0;
                        yFound  <= 1'b0;
                        xMed    <= '0;
                        yMed    <= '0;
                    end
                end
                READ: begin
                    tmo     <= tmo + 1'b1;
                    xValidD <= xValid;
                    yValidD <= yValid;
                    xDone   <= xDoneNow;
                    yDone   <= yDoneNow;
                    if (xWrEn) begin
                        xSum <= xSum + {8'd0, xHistogramIn};
                        xWr  <= xWr + 1'b1;
                    end
                    if (yWrEn) begin
                        ySum <= ySum + {8'd0, yHistogramIn};
                        yWr  <= yWr + 1'b1;
                    end
                end
                SCAN: begin
                    scanIdx <= scanIdx + 1'b1;
                    xCum    <= xCumNext;
                    yCum    <= yCumNext;
                    if (xHit) begin
                        xFound <= 1'b1;
                        xMed   <= scanIdx;
                    end
                    if (yHit) begin
                        yFound <= 1'b1;
                        yMed   <= scanIdx;
                    end
                    // Results load on the way into DONE so they appear with medianValid.
                    if (scanIdx == SCAN_LAST) begin
                        xMedian  <= xMedNext;
                        yMedian  <= yMedNext;
                        xTotal   <= xSum;
                        yTotal   <= ySum;
                        noObject <= (xSum == 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_median_reader.sv
module tb_histogram_median_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  xHistogramIn, yHistogramIn;
    logic        xValid, yValid, histogramCleared;
    logic        readHistogram, clearHistogram;
    logic [7:0]  xMedian, yMedian;
    logic [15:0] xTotal, yTotal;
    logic        noObject, medianValid, busy;

    histogram_median_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .xHistogramIn     (xHistogramIn),
        .yHistogramIn     (yHistogramIn),
        .xValid           (xValid),
        .yValid           (yValid),
        .histogramCleared (histogramCleared),
        .readHistogram    (readHistogram),
        .clearHistogram   (clearHistogram),
        .xMedian          (xMedian),
        .yMedian          (yMedian),
        .xTotal           (xTotal),
        .yTotal           (yTotal),
        .noObject         (noObject),
        .medianValid      (medianValid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] xVals [240];
    logic [7:0] yVals [180];

    // Observations from the last frame
    int readLen, gapLen, clearLen, scanLen, mvCount, busyLen;
    bit busyAfter, mvAfter, frameTimedOut;
    bit rstRead, rstClear, rstBusy, rstMv;
    logic [15:0] rstXTotal;
    logic [7:0]  rstXMedian;

    task automatic clearVals();
        for (int i = 0; i < 240; i++) xVals[i] = 8'd0;
        for (int i = 0; i < 180; i++) yVals[i] = 8'd0;
    endtask

    // Histogram-block model: streams the bins when readHistogram rises and
    // answers clearHistogram with histogramCleared after clrDelay cycles.
    task automatic runFrame(input int clrDelay, input bit sendData,
                            input int restartAt, input int resetAt);
        int  t;
        int  clrCnt;
        bit  seenClear, mvSeen, done;
        readLen = 0; gapLen = 0; clearLen = 0; scanLen = 0; mvCount = 0; busyLen = 0;
        busyAfter = 1'b0; mvAfter = 1'b0; frameTimedOut = 1'b0;
        clrCnt = 0; seenClear = 1'b0; mvSeen = 1'b0; done = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (!readHistogram && t < 10) begin @(posedge clk); #1; t++; end
        if (!readHistogram) begin
            vectors++; miscompares++;
            $display("FAIL frame_start readHistogram got 0 want 1");
            frameTimedOut = 1'b1;
            return;
        end
        t = 0;
        while (!done && t < 3000) begin
            if (mvSeen) begin
                busyAfter = busy; mvAfter = medianValid; done = 1'b1;
            end
            if (!done) begin
                if (readHistogram) readLen++;
                else if (clearHistogram) clearLen++;
                else if (medianValid) mvCount++;
                else if (busy) begin
                    if (!seenClear) gapLen++; else scanLen++;
                end
                if (clearHistogram) seenClear = 1'b1;
                if (busy) busyLen++;
                if (medianValid) mvSeen = 1'b1;
            end
            if (resetAt >= 0 && t == resetAt + 1) begin
                rstRead = readHistogram; rstClear = clearHistogram; rstBusy = busy;
                rstMv = medianValid; rstXTotal = xTotal; rstXMedian = xMedian;
                reset = 1'b0; done = 1'b1;
            end
            if (!done) begin
                if (sendData && t < 240) begin xValid = 1'b1; xHistogramIn = xVals[t]; end
                else begin xValid = 1'b0; xHistogramIn = 8'd0; end
                if (sendData && t < 180) begin yValid = 1'b1; yHistogramIn = yVals[t]; end
                else begin yValid = 1'b0; yHistogramIn = 8'd0; end
                if (clearHistogram) begin
                    clrCnt++;
                    histogramCleared = (clrCnt == clrDelay);
                end else histogramCleared = 1'b0;
                start = (restartAt >= 0) &&
                        (t == restartAt || (clearHistogram && clrCnt == restartAt));
                if (resetAt >= 0 && t == resetAt) reset = 1'b1;
                @(posedge clk); #1;
                t++;
            end
        end
        xValid = 1'b0; yValid = 1'b0; xHistogramIn = 8'd0; yHistogramIn = 8'd0;
        histogramCleared = 1'b0; start = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            frameTimedOut = 1'b1;
            $display("FAIL frame_timeout medianValid not seen within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; xValid = 1'b0; yValid = 1'b0;
        xHistogramIn = 8'd0; yHistogramIn = 8'd0; histogramCleared = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (readHistogram !== 1'b0) begin miscompares++; $display("FAIL reset readHistogram got %b want 0", readHistogram); end
        vectors++; if (clearHistogram !== 1'b0) begin miscompares++; $display("FAIL reset clearHistogram got %b want 0", clearHistogram); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
        vectors++; if (medianValid !== 1'b0) begin miscompares++; $display("FAIL reset medianValid got %b want 0", medianValid); end
        vectors++; if ({xMedian, yMedian} !== 16'd0) begin miscompares++; $display("FAIL reset medians got %0d/%0d want 0/0", xMedian, yMedian); end
        vectors++; if ({xTotal, yTotal, noObject} !== 33'd0) begin miscompares++; $display("FAIL reset totals got %0d/%0d noObject %b want 0/0/0", xTotal, yTotal, noObject); end
        // start together with reset: reset must win
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_vs_start busy got %b want 0", busy); end
    endtask

    task automatic test_all_zero();
        clearVals();
        runFrame(5, 1'b1, -1, -1);
        vectors++; if (readLen !== 241) begin miscompares++; $display("FAIL zero readLen got %0d want 241", readLen); end
        vectors++; if (gapLen !== 1) begin miscompares++; $display("FAIL zero gapLen got %0d want 1", gapLen); end
        vectors++; if (clearLen !== 5) begin miscompares++; $display("FAIL zero clearLen got %0d want 5", clearLen); end
        vectors++; if (scanLen !== 240) begin miscompares++; $display("FAIL zero scanLen got %0d want 240", scanLen); end
        vectors++; if (mvCount !== 1 || mvAfter !== 1'b0) begin miscompares++; $display("FAIL zero medianValid pulses got %0d (after %b) want 1 (0)", mvCount, mvAfter); end
        vectors++; if (xTotal !== 16'd0 || yTotal !== 16'd0) begin miscompares++; $display("FAIL zero totals got %0d/%0d want 0/0", xTotal, yTotal); end
        vectors++; if (noObject !== 1'b1) begin miscompares++; $display("FAIL zero noObject got %b want 1", noObject); end
        vectors++; if (xMedian !== 8'd0 || yMedian !== 8'd0) begin miscompares++; $display("FAIL zero medians got %0d/%0d want 0/0", xMedian, yMedian); end
    endtask

    task automatic test_single_bin();
        clearVals();
        xVals[100] = 8'd5; yVals[40] = 8'd5;
        runFrame(3, 1'b1, -1, -1);
        vectors++; if (xMedian !== 8'd100) begin miscompares++; $display("FAIL single xMedian got %0d want 100", xMedian); end
        vectors++; if (yMedian !== 8'd40) begin miscompares++; $display("FAIL single yMedian got %0d want 40", yMedian); end
        vectors++; if (xTotal !== 16'd5 || yTotal !== 16'd5) begin miscompares++; $display("FAIL single totals got %0d/%0d want 5/5", xTotal, yTotal); end
        vectors++; if (noObject !== 1'b0) begin miscompares++; $display("FAIL single noObject got %b want 0", noObject); end
    endtask

    task automatic test_split();
        clearVals();
        xVals[10] = 8'd2; xVals[20] = 8'd2;
        yVals[0] = 8'd1; yVals[1] = 8'd1; yVals[2] = 8'd1;
        runFrame(2, 1'b1, -1, -1);
        vectors++; if (xMedian !== 8'd10) begin miscompares++; $display("FAIL split xMedian got %0d want 10", xMedian); end
        vectors++; if (yMedian !== 8'd1) begin miscompares++; $display("FAIL split yMedian got %0d want 1", yMedian); end
        vectors++; if (xTotal !== 16'd4 || yTotal !== 16'd3) begin miscompares++; $display("FAIL split totals got %0d/%0d want 4/3", xTotal, yTotal); end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 240; i++) xVals[i] = 8'd255;
        for (int i = 0; i < 180; i++) yVals[i] = 8'd255;
        runFrame(1, 1'b1, -1, -1);
        vectors++; if (xTotal !== 16'd61200 || yTotal !== 16'd45900) begin miscompares++; $display("FAIL full totals got %0d/%0d want 61200/45900", xTotal, yTotal); end
        vectors++; if (xMedian !== 8'd119) begin miscompares++; $display("FAIL full xMedian got %0d want 119", xMedian); end
        vectors++; if (yMedian !== 8'd89) begin miscompares++; $display("FAIL full yMedian got %0d want 89", yMedian); end
    endtask

    task automatic test_last_bin();
        clearVals();
        xVals[239] = 8'd255; yVals[179] = 8'd1;
        runFrame(4, 1'b1, -1, -1);
        vectors++; if (xMedian !== 8'd239 || yMedian !== 8'd179) begin miscompares++; $display("FAIL last medians got %0d/%0d want 239/179", xMedian, yMedian); end
        vectors++; if (xTotal !== 16'd255 || yTotal !== 16'd1) begin miscompares++; $display("FAIL last totals got %0d/%0d want 255/1", xTotal, yTotal); end
    endtask

    task automatic test_back_to_back_start();
        clearVals();
        xVals[100] = 8'd5; yVals[40] = 8'd5;
        runFrame(239, 1'b1, 50, -1);
        vectors++; if (mvCount !== 1 || mvAfter !== 1'b0) begin miscompares++; $display("FAIL restart medianValid pulses got %0d (after %b) want 1 (0)", mvCount, mvAfter); end
        vectors++; if (clearLen !== 239) begin miscompares++; $display("FAIL restart clearLen got %0d want 239", clearLen); end
        vectors++; if (busyLen !== 241 + 1 + 239 + 240 + 1) begin miscompares++; $display("FAIL restart busyLen got %0d want %0d", busyLen, 722); end
        vectors++; if (busyAfter !== 1'b0) begin miscompares++; $display("FAIL restart busy after DONE got %b want 0", busyAfter); end
        vectors++; if (xMedian !== 8'd100 || yMedian !== 8'd40) begin miscompares++; $display("FAIL restart medians got %0d/%0d want 100/40", xMedian, yMedian); end
    endtask

    task automatic test_reset_mid_read();
        int extraMv;
        clearVals();
        runFrame(3, 1'b1, -1, 20);
        vectors++; if (rstRead !== 1'b0 || rstClear !== 1'b0) begin miscompares++; $display("FAIL midreset read/clear got %b/%b want 0/0", rstRead, rstClear); end
        vectors++; if (rstBusy !== 1'b0 || rstMv !== 1'b0) begin miscompares++; $display("FAIL midreset busy/mv got %b/%b want 0/0", rstBusy, rstMv); end
        vectors++; if (rstXTotal !== 16'd0 || rstXMedian !== 8'd0) begin miscompares++; $display("FAIL midreset results got %0d/%0d want 0/0", rstXTotal, rstXMedian); end
        extraMv = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (medianValid || busy) extraMv++;
        end
        vectors++; if (extraMv !== 0) begin miscompares++; $display("FAIL midreset activity after reset got %0d cycles want 0", extraMv); end
        xVals[7] = 8'd9; yVals[3] = 8'd4;
        runFrame(3, 1'b1, -1, -1);
        vectors++; if (xMedian !== 8'd7 || yMedian !== 8'd3 || xTotal !== 16'd9 || yTotal !== 16'd4) begin miscompares++; $display("FAIL postreset results got %0d/%0d %0d/%0d want 7/3 9/4", xMedian, yMedian, xTotal, yTotal); end
    endtask

    task automatic test_timeout();
        runFrame(3, 1'b0, -1, -1);
        vectors++; if (readLen !== 300) begin miscompares++; $display("FAIL timeout readLen got %0d want 300", readLen); end
        vectors++; if (scanLen !== 240 || mvCount !== 1) begin miscompares++; $display("FAIL timeout scan/mv got %0d/%0d want 240/1", scanLen, mvCount); end
        vectors++; if (noObject !== 1'b1 || xTotal !== 16'd0 || yTotal !== 16'd0) begin miscompares++; $display("FAIL timeout noObject/totals got %b %0d/%0d want 1 0/0", noObject, xTotal, yTotal); end
        vectors++; if (xMedian !== 8'd0 || yMedian !== 8'd0) begin miscompares++; $display("FAIL timeout medians got %0d/%0d want 0/0", xMedian, yMedian); end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_bin();
        test_split();
        test_full_scale();
        test_last_bin();
        test_back_to_back_start();
        test_reset_mid_read();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/histogram_median_reader.md
Name: histogram_median_reader

Overview:
- Reader/controller on the far side of the x/y projection histogram block.
- After a frame's histogram accumulation completes, it requests a readout (readHistogram) and captures the serial x/y projection streams into local buffers while summing totals.
- It then drives the histogram clear sequence and scans the buffers to find the median column and median row of the active pixels.
- Results go to the downstream filter/tracking logic.

Parameters:
- IMWIDTH, 240, x projection length (bins).
- IMHEIGHT, 180, y projection length (bins).
- READ_TIMEOUT, 300, max cycles spent in READ before forced exit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begin readout/clear/median cycle
- xHistogramIn  in  8  x projection bin value from histogram block
- yHistogramIn  in  8  y projection bin value from histogram block
- xValid  in  1  xHistogramIn carries a valid bin this cycle
- yValid  in  1  yHistogramIn carries a valid bin this cycle
- histogramCleared  in  1  histogram block has finished clearing both axes
- readHistogram  out  1  readout request, held high throughout READ
- clearHistogram  out  1  clear request, held high throughout CLEAR
- xMedian  out  8  median column index
- yMedian  out  8  median row index
- xTotal  out  16  sum of all captured x bins
- yTotal  out  16  sum of all captured y bins
- noObject  out  1  xTotal was zero for the last result
- medianValid  out  1  one-cycle pulse: results updated
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, internal counters and sums 0. Buffer contents are don't-care.
- Reset mid-operation: abandon the cycle. readHistogram and clearHistogram are 0 after the reset edge, and no medianValid pulse is produced.
- States: IDLE, READ, GAP, CLEAR, SCAN, DONE.
- IDLE:
  - start=1 moves to READ.
  - On entry to READ: clear write counters, sums and the timeout counter.
- READ:
  - readHistogram=1.
  - Each cycle with xValid=1 and xWr<IMWIDTH: xBuf[xWr]<=xHistogramIn, xSum+=xHistogramIn, xWr++. The y axis behaves identically with IMHEIGHT.
  - Valid samples beyond the buffer length are ignored.
  - An axis is done when its valid falls 1->0 after at least one sample, or when its write counter reaches its length.
  - Leave to GAP when both axes are done, or when the timeout counter reaches READ_TIMEOUT-1.
  - On timeout, unfilled bins are treated as 0.
- GAP:
  - Exactly one cycle with readHistogram=0 and clearHistogram=0, so the histogram block can rewind its counters. Then CLEAR.
- CLEAR:
  - clearHistogram=1, held until histogramCleared=1 is sampled.
  - clearHistogram is 0 on the following cycle; go to SCAN.
- SCAN:
  - Targets: xHalf=(xSum+1)>>1 and yHalf=(ySum+1)>>1, using 17-bit intermediate with no overflow.
  - Index i runs 0..max(IMWIDTH,IMHEIGHT)-1, one bin per cycle, both axes in parallel.
  - Running cumulative sum per axis, 16 bits. Bins at i >= axis write count contribute 0.
  - Axis median = smallest i where cumulative >= half. Latch it on the first hit and ignore later hits.
  - If the sum is 0, median=0.
  - Leave to DONE after the last index, so SCAN takes a fixed max(IMWIDTH,IMHEIGHT) cycles.
- DONE:
  - Update xMedian, yMedian, xTotal, yTotal and noObject (noObject = xSum==0).
  - medianValid=1 for this single cycle, then IDLE.
  - Results hold until the next DONE.
- start while busy=1 is ignored. start and reset together: reset wins.
- Arithmetic limits: max total 240*255=61200 fits 16 bits. Bin values are unsigned 8-bit.

Test Plan:
- All-zero histogram, start pulse -> readHistogram high during stream, one-cycle gap, clearHistogram until histogramCleared. Then medianValid pulse with xTotal=0, yTotal=0, noObject=1, xMedian=0, yMedian=0.
- x bin100=5, y bin40=5, others 0 -> xMedian=100, yMedian=40, xTotal=5, yTotal=5, noObject=0.
- x bins10=2 and 20=2 (total 4, half 2), y bins0=1, 1=1, 2=1 (half 2) -> xMedian=10, yMedian=1.
- Histogram block model returning histogramCleared after 239 cycles. start re-pulsed mid-READ and mid-CLEAR -> ignored. Exactly one medianValid, busy high from cycle after start until cycle after DONE.
- Reset asserted during READ -> next cycle readHistogram=0, busy=0, outputs 0. A following start completes normally.
- xValid/yValid never assert -> exit READ after READ_TIMEOUT cycles, complete CLEAR/SCAN, noObject=1, totals 0.
